// File: rtl/bootram_bus_bridge.sv
// ----------------------------------------------------------------------------
// bootram_bus_bridge
//
// Connects the PicoRV32 native memory port to four 2Kx8 single-port byte-lane
// boot RAMs. Together they form one 2K x 32 (8 KB) boot memory. The bridge
// drives chip-enable, output-enable and per-lane write-enable, and waits out
// the RAM read latency. It returns a one-cycle mem_ready pulse. mem_rdata is
// zero whenever mem_ready is low, so the read bus can be OR-muxed with other
// slaves.
//
// Parameters:
//   ADDR_W        word-address width per lane (2K entries -> 11)
//   READ_LATENCY  RAM cycles from CE edge to valid DO. Use 1 for bypass and
//                 2 for pipeline mode; in pipeline mode ram_oce is driven.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   sel                  address-decode hit for the boot RAM region
//   mem_valid/addr/      CPU request; mem_addr[ADDR_W+1:2] is the word index
//   wdata/wstrb          and the other bits are ignored (aliasing).
//                        wstrb=0000 means a read.
//   mem_ready/rdata      one-cycle completion pulse and read data
//   ram_ce/oce/wre/ad/din  lane controls; lane n uses byte n of din/dout
//   ram_dout             lane read data
//
// Configuration macro: BOOTRAM_WRITE_EN
//   defined   -> ram_wre follows mem_wstrb, so the loader can patch the RAM
//   undefined -> ram_wre is held at zero and the memory acts as a ROM.
//                Writes are still acknowledged.
// ----------------------------------------------------------------------------
module bootram_bus_bridge #(
  parameter int ADDR_W       = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic [3:0]        ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);
  // The pipeline output register only exists in the 2-cycle read mode.
  localparam logic       USE_OCE  = (READ_LATENCY == 2) ? 1'b1 : 1'b0;

  state_t     state_r;
  logic [1:0] lat_cnt_r;
  logic       is_write_r;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // Write-enable gating: the loader can write only when the feature is built in.
  function automatic logic [3:0] wre_gate(input logic [3:0] strb);
`ifdef BOOTRAM_WRITE_EN
    return strb;
`else
    return 4'b0000 & strb;
`endif
  endfunction

  // Bridge sequencer: handshake, RAM strobes, latency wait and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      lat_cnt_r  <= 2'd0;
      is_write_r <= 1'b0;
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'd0;
      ram_ce     <= 1'b0;
      ram_oce    <= 1'b0;
      ram_wre    <= 4'b0000;
      ram_ad     <= '0;
      ram_din    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
          if (mem_valid && sel && !mem_ready) begin
            ram_ad     <= mem_addr[ADDR_W+1:2];
            ram_din    <= mem_wdata;
            ram_ce     <= 1'b1;
            ram_wre    <= wre_gate(mem_wstrb);
            // Remember the access type separately; ram_wre may be gated off.
            is_write_r <= |mem_wstrb;
            state_r    <= ACCESS;
          end else begin
            ram_ce  <= 1'b0;
            ram_wre <= 4'b0000;
          end
        end
        ACCESS: begin
          ram_ce  <= 1'b0;
          ram_wre <= 4'b0000;
          if (is_write_r) begin
            mem_ready <= 1'b1;
            mem_rdata <= 32'd0;
            state_r   <= RESP;
          end else begin
            lat_cnt_r <= LAT_LOAD;
            ram_oce   <= USE_OCE;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_r != 2'd0) begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
          end else begin
            mem_rdata <= ram_dout;
            mem_ready <= 1'b1;
            ram_oce   <= 1'b0;
            state_r   <= RESP;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          lat_cnt_r <= 2'd0;
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
          ram_ce    <= 1'b0;
          ram_oce   <= 1'b0;
          ram_wre   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: doc/bootram_bus_bridge.md
Name: bootram_bus_bridge

Overview:
- Bridges the PicoRV32 native memory port to four 2Kx8 Gowin SP byte-lane boot RAMs, forming one 2K x 32 (8 KB) boot memory.
- Sits directly upstream of the byte-lane RAM instances; address decode has already produced `sel`.
- Sequences chip-enable, output-enable and per-lane write-enable.
- Waits out the RAM read latency, registers read data and returns a single-cycle `mem_ready`. `mem_rdata` is zero when idle, so the bus can be OR-muxed.

Parameters:
- ADDR_W, 11, word-address width per lane (2K entries).
- READ_LATENCY, 1, RAM cycles from CE edge to valid DO. Legal values: 1 (bypass READ_MODE=0) and 2 (pipeline READ_MODE=1, OCE used).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- sel  in  1  address decode hit for boot RAM region.
- mem_valid  in  1  CPU request valid.
- mem_addr  in  32  byte address; bits [ADDR_W+1:2] used, rest ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0000 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; 0 whenever mem_ready is low.
- ram_ce  out  1  common CE to all four lanes.
- ram_oce  out  1  common OCE to all four lanes.
- ram_wre  out  4  per-lane WRE; lane n carries byte n.
- ram_ad  out  ADDR_W  common lane address.
- ram_din  out  32  lane n DI = ram_din[8n+7:8n].
- ram_dout  in  32  lane n DO = ram_dout[8n+7:8n].

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values: mem_ready=0, mem_rdata=0, ram_ce=0, ram_oce=0, ram_wre=0, ram_ad=0, ram_din=0, state=IDLE, lat_cnt=0.
- Reset asserted mid-transaction aborts it:
  - Next cycle is IDLE with all outputs at reset values.
  - No mem_ready is issued.
  - A write whose CE was already issued may have completed in RAM. That is acceptable.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - On mem_valid & sel & !mem_ready: latch mem_addr[ADDR_W+1:2] into ram_ad and mem_wdata into ram_din.
  - Set ram_ce=1.
  - Set ram_wre = mem_wstrb (gated per Optional Feature).
  - Go to ACCESS.
  - Requests with sel=0 are ignored.
- ACCESS (CE high this cycle):
  - Next cycle ram_ce=0 and ram_wre=0.
  - If any strobe is set: go to RESP and set mem_ready=1 next cycle.
  - If read: load lat_cnt=READ_LATENCY-1 and go to WAIT.
  - With READ_LATENCY=2, set ram_oce=1 during WAIT.
- WAIT:
  - If lat_cnt≠0: decrement.
  - Otherwise capture mem_rdata<=ram_dout, set mem_ready=1, drop ram_oce, go to RESP.
- RESP:
  - mem_ready high exactly one cycle; mem_rdata holds captured data (0 for writes).
  - Next cycle: mem_ready=0, mem_rdata=0, go to IDLE.
- Latency, counting the request's first cycle in IDLE as cycle 0:
  - Write: mem_ready in cycle 2.
  - Read: mem_ready in cycle 2+READ_LATENCY.
- Back-to-back: the CPU drops mem_valid after mem_ready. The earliest next accept is the cycle after RESP, so there is no double accept.
- mem_valid dropping mid-transaction does not abort; the transaction completes and mem_ready still pulses.
- Address wrap: addresses beyond 8 KB alias modulo 2^ADDR_W words.
- Mixed strobes (e.g. 0011) write only the flagged lanes. Other lanes see WRE=0 but CE=1, which is harmless.

Optional Feature:
- Macro: BOOTRAM_WRITE_EN.
- Defined:
  - ram_wre follows mem_wstrb as above, so the loader can patch the boot RAM.
- Undefined:
  - ram_wre is held 4'b0000.
  - Write requests still run IDLE→ACCESS→RESP and acknowledge in cycle 2.
  - RAM contents are unchanged and mem_rdata=0 for the write.
  - The boot RAM behaves as ROM.

Test Plan:
- Read, READ_LATENCY=1: word 0x003 preloaded 0x5f4505b5, mem_addr=0x0000000C, wstrb=0 → ram_ce pulse at cycle 1 with ram_ad=3; mem_ready in cycle 3 only; mem_rdata=0x5f4505b5 that cycle and 0 otherwise.
- Write then read, BOOTRAM_WRITE_EN defined: wstrb=0101, wdata=0xAABBCCDD at 0x10 over 0x11223344 → ram_wre=0101 for one cycle, mem_ready in cycle 2; readback 0x11BB33DD.
- Same write, macro undefined → ram_wre never asserted, mem_ready in cycle 2, readback 0x11223344.
- READ_LATENCY=2 → ram_oce high during WAIT, mem_ready at cycle 4, data correct; sel=0 request → no CE, no mem_ready.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE, no mem_ready; a fresh read afterwards completes normally.
- Alias/back-to-back: read 0x2004 then immediately 0x0004 → both return word 1; exactly one mem_ready per request; mem_valid dropped during ACCESS still yields mem_ready.
